lfsr_msg_decoder: RTL and testbench

//  Hardware engine for programs 2/3: decrypts an LFSR-encrypted, parity-tagged message held in data memory.

---
 rtl/lfsr_pkg.sv | 27 ++
 rtl/lfsr_gen.sv | 38 +++
 rtl/lfsr_msg_decoder.sv | 217 +++++++++++++++++++++
 tb/tb_lfsr_msg_decoder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared constants, state encoding and parity helper for the LFSR message decoder.
package lfsr_pkg;

    localparam int DEF_LFSR_W = 7;
    localparam int NUM_TAPS   = 9;

    localparam logic [6:0] TAP_TBL [0:NUM_TAPS-1] = '{
        7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B
    };

    localparam logic [7:0] PAD_CHAR = 8'h20;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEED,
        ST_SEARCH,
        ST_DECODE,
        ST_PAD,
        ST_DONE
    } dec_state_t;

    // Returns 1 when the byte has odd overall parity, i.e. it was corrupted.
    function automatic logic parity(input logic [7:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/lfsr_gen.sv
// Fibonacci-style LFSR with synchronous load and step; one instance serves both
// the tap search and the decode pass.
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int W = DEF_LFSR_W
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] seed_i,
    input  logic         step_i,
    input  logic [W-1:0] tap_i,
    output logic [W-1:0] state_o
);

    logic [W-1:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = seed_i;
        end else if (step_i) begin
            state_d = {state_q[W-2:0], ^(state_q & tap_i)};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/lfsr_msg_decoder.sv
// Decrypts an LFSR-encrypted, parity-tagged message from data memory into the
// output region, recovering seed and tap pattern from the space-padded preamble.
//   state   | meaning
//   IDLE    | wait for req falling edge
//   SEED    | read byte 0, derive seed
//   SEARCH  | try tap k against preamble bytes 1..PRE_MIN-1
//   DECODE  | decrypt all bytes, drop leading spaces, write the rest
//   PAD     | fill remaining output slots with spaces
//   DONE    | ack high until req is seen again
module lfsr_msg_decoder
    import lfsr_pkg::*;
#(
    parameter int LFSR_W   = 7,
    parameter int MSG_LEN  = 64,
    parameter int IN_BASE  = 64,
    parameter int OUT_BASE = 0,
    parameter int PRE_MIN  = 10,
    parameter int NUM_PTRN = 9,
    parameter int ADDR_W   = 8
) (
    input  logic              clk,
    input  logic              init,
    input  logic              req,
    output logic              ack,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [LFSR_W:0]   rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [LFSR_W:0]   wr_data,
    output logic [3:0]        ptrn_idx,
    output logic              no_match
);

    localparam int CNT_W = $clog2(MSG_LEN + 1) + 1;
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_TWO   = CNT_W'(2);
    localparam logic [CNT_W-1:0]  CNT_PRE   = CNT_W'(PRE_MIN);
    localparam logic [CNT_W-1:0]  CNT_MSG   = CNT_W'(MSG_LEN);
    localparam logic [3:0]        LAST_PTRN = 4'(NUM_PTRN - 1);
    localparam logic [ADDR_W-1:0] A_ONE     = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_IN      = ADDR_W'(IN_BASE);
    localparam logic [ADDR_W-1:0] A_OUT     = ADDR_W'(OUT_BASE);
    localparam logic [LFSR_W-1:0] PAD_P     = PAD_CHAR[LFSR_W-1:0];

    dec_state_t        state_q, state_d;
    logic              req_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d, w_q, w_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
    logic [LFSR_W:0]   wr_data_q, wr_data_d;
    logic              wr_en_q, wr_en_d, skip_q, skip_d, no_match_q, no_match_d;
    logic [3:0]        ptrn_q, ptrn_d;
    logic [LFSR_W-1:0] seed_q, seed_d;
    logic              lfsr_load, lfsr_step;
    logic [LFSR_W-1:0] lfsr_s, plain;
    logic              perr, is_pad;

    lfsr_gen #(.W(LFSR_W)) u_lfsr (
        .clk_i   (clk),
        .rst_i   (init),
        .load_i  (lfsr_load),
        .seed_i  (seed_q),
        .step_i  (lfsr_step),
        .tap_i   (LFSR_W'(TAP_TBL[ptrn_q])),
        .state_o (lfsr_s)
    );

    assign plain  = rd_data[LFSR_W-1:0] ^ lfsr_s;
    assign perr   = parity(rd_data);
    assign is_pad = (plain == PAD_P);

    always_ff @(posedge clk) begin
        if (init) begin
            state_q    <= ST_IDLE;
            req_q      <= 1'b0;
            cnt_q      <= '0;
            w_q        <= '0;
            rd_addr_q  <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_en_q    <= 1'b0;
            skip_q     <= 1'b0;
            no_match_q <= 1'b0;
            ptrn_q     <= '0;
            seed_q     <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req;
            cnt_q      <= cnt_d;
            w_q        <= w_d;
            rd_addr_q  <= rd_addr_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_en_q    <= wr_en_d;
            skip_q     <= skip_d;
            no_match_q <= no_match_d;
            ptrn_q     <= ptrn_d;
            seed_q     <= seed_d;
        end
    end

    // Read data lags rd_addr by one cycle; the LFSR is stepped so that its state
    // always matches the byte currently on rd_data.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        w_d        = w_q;
        rd_addr_d  = rd_addr_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_en_d    = 1'b0;
        skip_d     = skip_q;
        no_match_d = no_match_q;
        ptrn_d     = ptrn_q;
        seed_d     = seed_q;
        lfsr_load  = 1'b0;
        lfsr_step  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_q && !req) begin
                    state_d    = ST_SEED;
                    cnt_d      = '0;
                    rd_addr_d  = A_IN;
                    ptrn_d     = '0;
                    no_match_d = 1'b0;
                end
            end
            ST_SEED: begin
                if (cnt_q == '0) begin
                    cnt_d = CNT_ONE;
                end else begin
                    seed_d  = rd_data[LFSR_W-1:0] ^ PAD_P;
                    state_d = ST_SEARCH;
                    cnt_d   = '0;
                end
            end
            ST_SEARCH: begin
                if (cnt_q == '0) begin
                    lfsr_load = 1'b1;
                    rd_addr_d = A_IN + A_ONE;
                    cnt_d     = CNT_ONE;
                end else begin
                    lfsr_step = 1'b1;
                    rd_addr_d = rd_addr_q + A_ONE;
                    cnt_d     = cnt_q + CNT_ONE;
                    if (cnt_q >= CNT_TWO) begin
                        if (!is_pad) begin
                            cnt_d = '0;
                            if (ptrn_q == LAST_PTRN) begin
                                no_match_d = 1'b1;
                                ptrn_d     = '0;
                                state_d    = ST_DECODE;
                                rd_addr_d  = A_IN;
                            end else begin
                                ptrn_d = ptrn_q + 4'd1;
                            end
                        end else if (cnt_q == CNT_PRE) begin
                            state_d   = ST_DECODE;
                            cnt_d     = '0;
                            rd_addr_d = A_IN;
                        end
                    end
                end
            end
            ST_DECODE: begin
                if (cnt_q == '0) begin
                    lfsr_load = 1'b1;
                    skip_d    = 1'b1;
                    w_d       = '0;
                    rd_addr_d = rd_addr_q + A_ONE;
                    cnt_d     = CNT_ONE;
                end else begin
                    lfsr_step = 1'b1;
                    rd_addr_d = rd_addr_q + A_ONE;
                    cnt_d     = cnt_q + CNT_ONE;
                    if (!(skip_q && is_pad && !perr)) begin
                        skip_d    = 1'b0;
                        wr_en_d   = 1'b1;
                        wr_addr_d = A_OUT + ADDR_W'(w_q);
                        wr_data_d = {perr, plain};
                        w_d       = w_q + CNT_ONE;
                    end
                    if (cnt_q == CNT_MSG) begin
                        cnt_d   = '0;
                        state_d = (w_d == CNT_MSG) ? ST_DONE : ST_PAD;
                    end
                end
            end
            ST_PAD: begin
                wr_en_d   = 1'b1;
                wr_addr_d = A_OUT + ADDR_W'(w_q);
                wr_data_d = {1'b0, PAD_P};
                w_d       = w_q + CNT_ONE;
                if (w_d == CNT_MSG) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (req) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ack = (state_q == ST_DONE);
    end

    assign rd_addr  = rd_addr_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign ptrn_idx = ptrn_q;
    assign no_match = no_match_q;

endmodule

// File: tb/tb_lfsr_msg_decoder.sv
// Directed bench for lfsr_msg_decoder: encrypts known messages into a memory
// model and checks the plaintext region, pattern index and handshake.
module tb_lfsr_msg_decoder;

    logic       clk = 1'b0;
    logic       init, req, ack, wr_en, no_match;
    logic [7:0] rd_addr, rd_data, wr_addr, wr_data;
    logic [3:0] ptrn_idx;

    logic [7:0] in_mem  [0:255];
    logic [7:0] out_mem [0:255];
    logic [6:0] pt      [0:63];
    logic [7:0] exp_out [0:63];
    int wr_cnt = 0;
    int bad_wr = 0;
    int n_cmp  = 0;
    int n_err  = 0;
    string msg  = "    four score and seven years ago...";
    string body = "four score and seven years ago...";

    lfsr_msg_decoder dut (
        .clk      (clk),
        .init     (init),
        .req      (req),
        .ack      (ack),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .ptrn_idx (ptrn_idx),
        .no_match (no_match)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rd_data <= in_mem[rd_addr];
        if (wr_en === 1'b1) begin
            out_mem[wr_addr] <= wr_data;
            wr_cnt <= wr_cnt + 1;
            if (wr_addr >= 8'd64) bad_wr <= bad_wr + 1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic build(input int pre, input logic [6:0] seed, input logic [6:0] tap);
        logic [6:0] s, e;
        byte ch;
        s = seed;
        for (int i = 0; i < 64; i++) begin
            if (i < pre || i - pre >= msg.len()) begin
                pt[i] = 7'h20;
            end else begin
                ch    = msg.getc(i - pre);
                pt[i] = ch[6:0];
            end
            e = pt[i] ^ s;
            in_mem[64+i] = {^e, e};
            s = {s[5:0], ^(s & tap)};
        end
    endtask

    task automatic set_exp_body();
        for (int i = 0; i < 64; i++) begin
            exp_out[i] = (i < body.len()) ? body.getc(i) : 8'h20;
        end
    endtask

    task automatic do_run(output int cycles, output bit ok);
        @(negedge clk) req = 1'b1;
        @(negedge clk) req = 1'b0;
        cycles = 0;
        ok = 1'b0;
        while (cycles < 300 && !ok) begin
            @(negedge clk);
            cycles++;
            if (ack === 1'b1) ok = 1'b1;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        init = 1'b1;
        req  = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (ack !== 1'b0)      begin n_err++; $display("FAIL rst_ack got=%b want=0", ack); end
        n_cmp++; if (wr_en !== 1'b0)    begin n_err++; $display("FAIL rst_wr_en got=%b want=0", wr_en); end
        n_cmp++; if (no_match !== 1'b0) begin n_err++; $display("FAIL rst_no_match got=%b want=0", no_match); end
        n_cmp++; if (ptrn_idx !== 4'd0) begin n_err++; $display("FAIL rst_ptrn_idx got=%0d want=0", ptrn_idx); end
        n_cmp++; if (rd_addr !== 8'd0)  begin n_err++; $display("FAIL rst_rd_addr got=%h want=00", rd_addr); end
        n_cmp++; if (wr_addr !== 8'd0)  begin n_err++; $display("FAIL rst_wr_addr got=%h want=00", wr_addr); end
        init = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_t1_basic();
        int cyc, w0;
        bit ok;
        build(10, 7'h01, 7'h60);
        set_exp_body();
        w0 = wr_cnt;
        do_run(cyc, ok);
        n_cmp++; if (ok !== 1'b1 || ack !== 1'b1) begin n_err++; $display("FAIL t1_ack got=%b want=1", ack); end
        n_cmp++; if (ptrn_idx !== 4'd0) begin n_err++; $display("FAIL t1_ptrn_idx got=%0d want=0", ptrn_idx); end
        n_cmp++; if (no_match !== 1'b0) begin n_err++; $display("FAIL t1_no_match got=%b want=0", no_match); end
        n_cmp++; if (wr_cnt - w0 != 64) begin n_err++; $display("FAIL t1_wr_count got=%0d want=64", wr_cnt - w0); end
        n_cmp++; if (out_mem[0] !== 8'h66) begin n_err++; $display("FAIL t1_first got=%h want=66", out_mem[0]); end
        for (int i = 0; i < 64; i++) begin
            n_cmp++;
            if (out_mem[i] !== exp_out[i]) begin
                n_err++; $display("FAIL t1_out[%0d] got=%h want=%h", i, out_mem[i], exp_out[i]);
            end
        end
    endtask

    task automatic test_t5_all_zero();
        int cyc, w0, b0;
        bit ok;
        for (int i = 64; i < 128; i++) in_mem[i] = 8'h00;
        w0 = wr_cnt;
        b0 = bad_wr;
        do_run(cyc, ok);
        n_cmp++; if (ok !== 1'b1 || cyc > 220) begin n_err++; $display("FAIL t5_latency got=%0d want<=220", cyc); end
        n_cmp++; if (no_match !== 1'b1) begin n_err++; $display("FAIL t5_no_match got=%b want=1", no_match); end
        n_cmp++; if (ptrn_idx !== 4'd0) begin n_err++; $display("FAIL t5_ptrn_idx got=%0d want=0", ptrn_idx); end
        n_cmp++; if (bad_wr != b0) begin n_err++; $display("FAIL t5_out_of_range got=%0d want=0", bad_wr - b0); end
        n_cmp++; if (wr_cnt - w0 != 64) begin n_err++; $display("FAIL t5_wr_count got=%0d want=64", wr_cnt - w0); end
        n_cmp++; if (out_mem[0] !== 8'h41) begin n_err++; $display("FAIL t5_first got=%h want=41", out_mem[0]); end
    endtask

    task automatic test_t2_last_tap();
        int cyc, w0;
        bit ok;
        build(26, 7'h5A, 7'h7B);
        set_exp_body();
        w0 = wr_cnt;
        do_run(cyc, ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL t2_ack got=%b want=1", ack); end
        n_cmp++; if (ptrn_idx !== 4'd8) begin n_err++; $display("FAIL t2_ptrn_idx got=%0d want=8", ptrn_idx); end
        n_cmp++; if (no_match !== 1'b0) begin n_err++; $display("FAIL t2_no_match got=%b want=0", no_match); end
        n_cmp++; if (wr_cnt - w0 != 64) begin n_err++; $display("FAIL t2_wr_count got=%0d want=64", wr_cnt - w0); end
        for (int i = 0; i < 64; i++) begin
            n_cmp++;
            if (out_mem[i] !== exp_out[i]) begin
                n_err++; $display("FAIL t2_out[%0d] got=%h want=%h", i, out_mem[i], exp_out[i]);
            end
        end
    endtask

    task automatic test_t3_msg_flip();
        int cyc;
        bit ok;
        build(10, 7'h01, 7'h60);
        in_mem[64+30] = in_mem[64+30] ^ 8'h01;
        set_exp_body();
        exp_out[16] = 8'hE4;
        do_run(cyc, ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL t3_ack got=%b want=1", ack); end
        n_cmp++; if (out_mem[16] !== 8'hE4) begin n_err++; $display("FAIL t3_flagged got=%h want=e4", out_mem[16]); end
        for (int i = 0; i < 64; i++) begin
            n_cmp++;
            if (out_mem[i] !== exp_out[i]) begin
                n_err++; $display("FAIL t3_out[%0d] got=%h want=%h", i, out_mem[i], exp_out[i]);
            end
        end
    endtask

    task automatic test_t4_preamble_flip();
        int cyc;
        bit ok;
        build(26, 7'h5A, 7'h7B);
        in_mem[64+24] = in_mem[64+24] ^ 8'h80;
        exp_out[0] = 8'hA0;
        for (int i = 1; i < 64; i++) exp_out[i] = (i < 40) ? {1'b0, pt[24+i]} : 8'h20;
        do_run(cyc, ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL t4_ack got=%b want=1", ack); end
        n_cmp++; if (ptrn_idx !== 4'd8) begin n_err++; $display("FAIL t4_ptrn_idx got=%0d want=8", ptrn_idx); end
        n_cmp++; if (out_mem[6] !== 8'h66) begin n_err++; $display("FAIL t4_f_pos got=%h want=66", out_mem[6]); end
        for (int i = 0; i < 64; i++) begin
            n_cmp++;
            if (out_mem[i] !== exp_out[i]) begin
                n_err++; $display("FAIL t4_out[%0d] got=%h want=%h", i, out_mem[i], exp_out[i]);
            end
        end
    endtask

    task automatic test_t6_mid_reset();
        int n, wc, cyc;
        bit ok;
        build(10, 7'h01, 7'h60);
        set_exp_body();
        @(negedge clk) req = 1'b1;
        @(negedge clk) req = 1'b0;
        n = 0;
        while (n < 300 && wr_en !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        n_cmp++; if (wr_en !== 1'b1) begin n_err++; $display("FAIL t6_reach_decode got=%b want=1", wr_en); end
        repeat (5) @(negedge clk);
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        n_cmp++; if (wr_en !== 1'b0)    begin n_err++; $display("FAIL t6_wr_en got=%b want=0", wr_en); end
        n_cmp++; if (ack !== 1'b0)      begin n_err++; $display("FAIL t6_ack got=%b want=0", ack); end
        n_cmp++; if (rd_addr !== 8'd0)  begin n_err++; $display("FAIL t6_rd_addr got=%h want=00", rd_addr); end
        n_cmp++; if (wr_addr !== 8'd0)  begin n_err++; $display("FAIL t6_wr_addr got=%h want=00", wr_addr); end
        wc = wr_cnt;
        repeat (10) @(negedge clk);
        n_cmp++; if (wr_cnt != wc) begin n_err++; $display("FAIL t6_idle_writes got=%0d want=0", wr_cnt - wc); end
        n_cmp++; if (ack !== 1'b0) begin n_err++; $display("FAIL t6_idle_ack got=%b want=0", ack); end
        do_run(cyc, ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL t6_rerun_ack got=%b want=1", ack); end
        n_cmp++; if (ptrn_idx !== 4'd0) begin n_err++; $display("FAIL t6_ptrn_idx got=%0d want=0", ptrn_idx); end
        for (int i = 0; i < 64; i++) begin
            n_cmp++;
            if (out_mem[i] !== exp_out[i]) begin
                n_err++; $display("FAIL t6_out[%0d] got=%h want=%h", i, out_mem[i], exp_out[i]);
            end
        end
    endtask

    initial begin
        init = 1'b1;
        req  = 1'b0;
        for (int i = 0; i < 256; i++) in_mem[i] = 8'h00;
        test_reset();
        test_t1_basic();
        test_t5_all_zero();
        test_t2_last_tap();
        test_t3_msg_flip();
        test_t4_preamble_flip();
        test_t6_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
